// File: rtl/mult_frac_pkg.sv
// Shared constants and state encoding for the Q1.3 x Q1.3 sequential fractional multiplier.
package mult_frac_pkg;
   localparam int N  = 4;
   localparam int PW = 2 * N - 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // +63/64, the closest representable value to +1 in Q1.6.
   localparam logic [PW-1:0] SAT_POS = 7'b0111111;
endpackage

// File: rtl/mult_frac_addsub.sv
// Sign-extended (N+1)-bit adder/subtractor used by one multiplier iteration.
module mult_frac_addsub
   import mult_frac_pkg::*;
(
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N:0]   sum
);

   logic [N:0] a_ext;
   logic [N:0] b_ext;

   always_comb begin
      a_ext = {a[N-1], a};
      b_ext = {b[N-1], b};
      sum   = sub ? (a_ext - b_ext) : (a_ext + b_ext);
   end

endmodule

// File: rtl/mult2c_frac_4bit.sv
// Sequential shift-and-add multiplier for Q1.3 two's-complement fractions giving a Q1.6 product.
// Start/done handshake; done pulses one cycle, five cycles after the start edge.
module mult2c_frac_4bit
   import mult_frac_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          st,
   input  logic [N-1:0]  mplier,
   input  logic [N-1:0]  mcand,
   output logic [PW-1:0] product,
   output logic          done
);

   state_t        state_q, state_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [N-1:0]  c_q, c_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [PW-1:0] product_q, product_d;
   logic          done_q, done_d;

   logic [N-1:0]  addend;
   logic          last_iter;
   logic [N:0]    sum;

   // The final iteration handles the multiplier sign bit, whose weight is negative.
   assign last_iter = (cnt_q == 2'd3);
   assign addend    = b_q[0] ? c_q : '0;

   mult_frac_addsub u_addsub (
      .a   (a_q),
      .b   (addend),
      .sub (last_iter),
      .sum (sum)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (st) begin
               c_d     = mcand;
               b_d     = mplier;
               a_d     = '0;
               cnt_d   = 2'd0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            a_d   = sum[N:1];
            b_d   = {sum[0], b_q[N-1:1]};
            cnt_d = cnt_q + 2'd1;
            if (last_iter) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               // Bits 7 and 6 of the full product differ only for -1 x -1.
               if (sum[N] != sum[N-1])
                  product_d = SAT_POS;
               else
                  product_d = {sum[N-1:0], b_q[N-1:1]};
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         cnt_q     <= 2'd0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         c_q       <= c_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   assign product = product_q;
   assign done    = done_q;

endmodule

// File: tb/tb_mult2c_frac_4bit.sv
// Self-checking bench for mult2c_frac_4bit: directed, random, reset-abort and handshake scenarios.
module tb_mult2c_frac_4bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       st;
   logic [3:0] mplier;
   logic [3:0] mcand;
   logic [6:0] product;
   logic       done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mult2c_frac_4bit dut (
      .clk     (clk),
      .rst     (rst),
      .st      (st),
      .mplier  (mplier),
      .mcand   (mcand),
      .product (product),
      .done    (done)
   );

   // Reference: integer product in units of 1/64, saturated at +63/64.
   function automatic int ref_prod(input logic [3:0] mc, input logic [3:0] mp);
      int a;
      int b;
      int p;
      a = $signed(mc);
      b = $signed(mp);
      p = a * b;
      if (p > 63) p = 63;
      return p;
   endfunction

   function automatic int as_int(input logic [6:0] v);
      logic signed [7:0] s;
      s = {v[6], v};
      return int'(s);
   endfunction

   // Starts one operation from IDLE and waits (bounded) for done.
   task automatic run_op(input logic [3:0] mc, input logic [3:0] mp, input bit pulse_mid,
                         output logic [6:0] prod, output int lat, output bit narrow);
      @(negedge clk);
      mcand  = mc;
      mplier = mp;
      st     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      st     = 1'b0;
      mcand  = 4'($urandom);
      mplier = 4'($urandom);
      lat    = 0;
      for (int i = 1; i <= 20; i++) begin
         if (i > 1) @(negedge clk);
         if (pulse_mid) st = (i == 2);
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
      st   = 1'b0;
      prod = product;
      @(negedge clk);
      narrow = (done === 1'b0);
   endtask

   task automatic check_op(input string name, input logic [3:0] mc, input logic [3:0] mp,
                           input int exp_val, input logic [6:0] prod, input int lat, input bit narrow);
      int got;
      got = as_int(prod);
      $display("%s: mcand=%b mplier=%b product=%b (%0d/64) exp=%0d/64 latency=%0d",
               name, mc, mp, prod, got, exp_val, lat);
      checks++;
      if (got !== exp_val) begin
         failures++;
         $display("FAIL %s_product: got %0d/64 (%b) expected %0d/64", name, got, prod, exp_val);
      end
      checks++;
      if (lat !== 5) begin
         failures++;
         $display("FAIL %s_latency: got %0d expected 5 (0 means watchdog timeout)", name, lat);
      end
      checks++;
      if (narrow !== 1'b1) begin
         failures++;
         $display("FAIL %s_done_width: done still high the cycle after, expected one-cycle pulse", name);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; st = 1'b0; mcand = '0; mplier = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (product !== 7'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_in: product=%b done=%b expected 0000000/0", product, done);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (product !== 7'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_after: product=%b done=%b expected 0000000/0", product, done);
      end
      $display("reset: product=%b done=%b", product, done);
   endtask

   task automatic test_directed();
      logic [3:0] mc_t [8] = '{4'b0101, 4'b1101, 4'b0101, 4'b1101, 4'b0111, 4'b1000, 4'b1000, 4'b0000};
      logic [3:0] mp_t [8] = '{4'b0101, 4'b0101, 4'b1101, 4'b1101, 4'b0101, 4'b0111, 4'b1000, 4'b1000};
      int         ex_t [8] = '{25, -15, -15, 9, 35, -56, 63, 0};
      logic [6:0] prod;
      int         lat;
      bit         narrow;
      for (int i = 0; i < 8; i++) begin
         run_op(mc_t[i], mp_t[i], 1'b0, prod, lat, narrow);
         check_op("directed", mc_t[i], mp_t[i], ex_t[i], prod, lat, narrow);
      end
   endtask

   task automatic test_random();
      logic [3:0] mc;
      logic [3:0] mp;
      logic [6:0] prod;
      int         lat;
      bit         narrow;
      for (int i = 0; i < 40; i++) begin
         mc = 4'($urandom);
         mp = 4'($urandom);
         run_op(mc, mp, 1'b0, prod, lat, narrow);
         check_op("random", mc, mp, ref_prod(mc, mp), prod, lat, narrow);
      end
   endtask

   task automatic test_rst_mid();
      bit         saw_done;
      logic [6:0] prod;
      int         lat;
      bit         narrow;
      @(negedge clk);
      mcand = 4'b0111; mplier = 4'b0111; st = 1'b1;
      @(negedge clk);
      st = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      $display("rst_mid: product=%b saw_done=%0d", product, saw_done);
      checks++;
      if (saw_done !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_done: done seen=%0d expected 0", saw_done);
      end
      checks++;
      if (product !== 7'b0) begin
         failures++;
         $display("FAIL rst_mid_product: got %b expected 0000000", product);
      end
      run_op(4'b1101, 4'b0101, 1'b0, prod, lat, narrow);
      check_op("after_rst", 4'b1101, 4'b0101, -15, prod, lat, narrow);
   endtask

   task automatic test_st_during_calc();
      logic [6:0] prod;
      int         lat;
      bit         narrow;
      bit         extra;
      run_op(4'b0110, 4'b1011, 1'b1, prod, lat, narrow);
      check_op("st_in_calc", 4'b0110, 4'b1011, ref_prod(4'b0110, 4'b1011), prod, lat, narrow);
      extra = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done === 1'b1) extra = 1'b1;
      end
      checks++;
      if (extra !== 1'b0) begin
         failures++;
         $display("FAIL st_in_calc_extra: extra done pulse seen, expected none");
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] prod;
      int         lat;
      bit         narrow;
      run_op(4'b1001, 4'b0011, 1'b0, prod, lat, narrow);
      check_op("b2b_first", 4'b1001, 4'b0011, ref_prod(4'b1001, 4'b0011), prod, lat, narrow);
      run_op(4'b0011, 4'b1110, 1'b0, prod, lat, narrow);
      check_op("b2b_second", 4'b0011, 4'b1110, ref_prod(4'b0011, 4'b1110), prod, lat, narrow);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_rst_mid();
      test_st_during_calc();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
